// File: rtl/alu_sequencer.sv
// Three-state operand issuer / write-back controller for the shared adder ALU.
// Owns a register file (entry 0 hardwired to zero) and drives ALU operands from latched registers.
module alu_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  use_imm,
    input  logic                  is_branch,
    output logic                  ALUctrl,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    input  logic [DATA_WIDTH-1:0] ALUout,
    input  logic                  EQ,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  branch_taken,
    output logic [DATA_WIDTH-1:0] a0,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    state_t                state_q;
    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  is_branch_q;
    logic                  alu_ctrl_q;
    logic                  done_q;
    logic                  taken_q;

    function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [ADDR_WIDTH-1:0] idx,
                                                      input logic [DATA_WIDTH-1:0] val);
        return (idx == ZERO_IDX) ? ZERO_DATA : val;
    endfunction

    // Sequencer FSM, operand/result registers and register-file write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op1_q       <= ZERO_DATA;
            op2_q       <= ZERO_DATA;
            result_q    <= ZERO_DATA;
            rd_q        <= ZERO_IDX;
            is_branch_q <= 1'b0;
            alu_ctrl_q  <= 1'b0;
            done_q      <= 1'b0;
            taken_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= ZERO_DATA;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op1_q       <= rf_read(rs1, regs_q[rs1]);
                        op2_q       <= use_imm ? imm : rf_read(rs2, regs_q[rs2]);
                        rd_q        <= rd;
                        is_branch_q <= is_branch;
                        alu_ctrl_q  <= 1'b1;
                        state_q     <= EXEC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    result_q   <= ALUout;
                    if (is_branch_q) begin
                        taken_q <= EQ;
                    end else begin
                        taken_q <= taken_q;
                    end
                    alu_ctrl_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= WB;
                end
                WB: begin
                    // Entry 0 is never written so it keeps reading as zero.
                    if (!is_branch_q && (rd_q != ZERO_IDX)) begin
                        regs_q[rd_q] <= result_q;
                    end else begin
                        regs_q[0] <= ZERO_DATA;
                    end
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    alu_ctrl_q <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset so it is low during reset and high in the first released cycle.
    assign req_ready    = rst & (state_q == IDLE);
    assign ALUctrl      = alu_ctrl_q;
    assign ALUop1       = op1_q;
    assign ALUop2       = op2_q;
    assign done         = done_q;
    assign result       = result_q;
    assign branch_taken = taken_q;
    assign a0           = regs_q[A0_IDX];
    assign dbg_data     = rf_read(dbg_addr, regs_q[dbg_addr]);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: an adder/comparator ALU model closes the loop,
// and each scenario task checks protocol timing, operands, results and register contents.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic [31:0] imm = 32'd0;
    logic        use_imm = 1'b0, is_branch = 1'b0;
    logic        ALUctrl;
    logic [31:0] ALUop1, ALUop2, ALUout;
    logic        EQ;
    logic        done;
    logic [31:0] result;
    logic        branch_taken;
    logic [31:0] a0;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Reference ALU: wrapping add and equality compare.
    assign ALUout = ALUop1 + ALUop2;
    assign EQ     = (ALUop1 == ALUop2);

    alu_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm), .is_branch(is_branch),
        .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUout(ALUout), .EQ(EQ),
        .done(done), .result(result), .branch_taken(branch_taken), .a0(a0),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Issue one request and follow it through EXEC and WB back to IDLE.
    task automatic run_req(input string name, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rdv, input logic [31:0] immv, input logic ui,
                           input logic br, input logic [31:0] e_op1, input logic [31:0] e_op2,
                           input logic [31:0] e_res);
        int waitc = 0;
        @(negedge clk);
        while (!req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: got %b expected 1", name, req_ready);
        end
        rs1 = r1; rs2 = r2; rd = rdv; imm = immv; use_imm = ui; is_branch = br;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rs1 = 5'd31; rs2 = 5'd31; rd = 5'd31; imm = 32'hDEAD_BEEF; use_imm = 1'b0; is_branch = 1'b0;
        n_checks++;
        if (ALUctrl !== 1'b1 || ALUop1 !== e_op1 || ALUop2 !== e_op2 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_exec: got ctrl=%b op1=%h op2=%h done=%b expected ctrl=1 op1=%h op2=%h done=0",
                     name, ALUctrl, ALUop1, ALUop2, done, e_op1, e_op2);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || ALUctrl !== 1'b0 || result !== e_res || ALUop1 !== e_op1 || ALUop2 !== e_op2) begin
            n_fail++;
            $display("FAIL %s_wb: got done=%b ctrl=%b result=%h op1=%h op2=%h expected done=1 ctrl=0 result=%h",
                     name, done, ALUctrl, result, ALUop1, ALUop2, e_res);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: got done=%b ready=%b expected done=0 ready=1", name, done, req_ready);
        end
    endtask

    task automatic check_reg(input string name, input logic [4:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        n_checks++;
        if (dbg_data !== exp) begin
            n_fail++;
            $display("FAIL %s: reg[%0d] got %h expected %h", name, idx, dbg_data, exp);
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ALUctrl !== 1'b0 || done !== 1'b0 || result !== 32'd0 || branch_taken !== 1'b0 ||
            ALUop1 !== 32'd0 || ALUop2 !== 32'd0 || a0 !== 32'd0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctrl=%b done=%b result=%h taken=%b op1=%h op2=%h a0=%h ready=%b expected all 0",
                     ALUctrl, done, result, branch_taken, ALUop1, ALUop2, a0, req_ready);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            if (dbg_data !== 32'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_regfile: %0d nonzero entries expected 0", bad);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_imm_and_dependent;
        run_req("imm_load", 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b0, 32'd0, 32'd5, 32'd5);
        check_reg("imm_load_reg1", 5'd1, 32'd5);
        run_req("dep_add", 5'd1, 5'd1, 5'd10, 32'd99, 1'b0, 1'b0, 32'd5, 32'd5, 32'd10);
        n_checks++;
        if (a0 !== 32'd10) begin
            n_fail++;
            $display("FAIL dep_add_a0: got %h expected %h", a0, 32'd10);
        end
    endtask

    task automatic test_wrap;
        run_req("wrap_load", 5'd0, 5'd0, 5'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_reg("wrap_load_reg3", 5'd3, 32'hFFFF_FFFF);
        run_req("wrap_add", 5'd3, 5'd0, 5'd3, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check_reg("wrap_reg3", 5'd3, 32'd0);
    endtask

    task automatic test_write_x0;
        run_req("x0_write", 5'd0, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0, 32'd0, 32'd7, 32'd7);
        check_reg("x0_reg0", 5'd0, 32'd0);
        run_req("x0_read", 5'd0, 5'd0, 5'd7, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_branch;
        run_req("br_load1", 5'd0, 5'd0, 5'd1, 32'd9, 1'b1, 1'b0, 32'd0, 32'd9, 32'd9);
        run_req("br_load2", 5'd0, 5'd0, 5'd2, 32'd9, 1'b1, 1'b0, 32'd0, 32'd9, 32'd9);
        run_req("br_eq", 5'd1, 5'd2, 5'd4, 32'd0, 1'b0, 1'b1, 32'd9, 32'd9, 32'd18);
        n_checks++;
        if (branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL br_eq_taken: got %b expected 1", branch_taken);
        end
        check_reg("br_eq_reg4", 5'd4, 32'd0);
        run_req("br_load2b", 5'd0, 5'd0, 5'd2, 32'd8, 1'b1, 1'b0, 32'd0, 32'd8, 32'd8);
        n_checks++;
        if (branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL nonbranch_keeps_taken: got %b expected 1", branch_taken);
        end
        run_req("br_ne", 5'd1, 5'd2, 5'd4, 32'd0, 1'b0, 1'b1, 32'd9, 32'd8, 32'd17);
        n_checks++;
        if (branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL br_ne_taken: got %b expected 0", branch_taken);
        end
        check_reg("br_ne_reg4", 5'd4, 32'd0);
        run_req("post_br_add", 5'd1, 5'd0, 5'd6, 32'd1, 1'b1, 1'b0, 32'd9, 32'd1, 32'd10);
        n_checks++;
        if (branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL post_br_taken: got %b expected 0", branch_taken);
        end
        check_reg("post_br_reg6", 5'd6, 32'd10);
    endtask

    task automatic test_reset_mid_exec;
        int done_seen = 0;
        @(negedge clk);
        rs1 = 5'd0; rd = 5'd5; imm = 32'd3; use_imm = 1'b1; is_branch = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (ALUctrl !== 1'b1 || ALUop2 !== 32'd3) begin
            n_fail++;
            $display("FAIL midrst_exec: got ctrl=%b op2=%h expected ctrl=1 op2=%h", ALUctrl, ALUop2, 32'd3);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ALUctrl !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0 || result !== 32'd0 || a0 !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got ctrl=%b done=%b ready=%b result=%h a0=%h expected all 0",
                     ALUctrl, done, req_ready, result, a0);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) done_seen++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            #1;
            if (done !== 1'b0) done_seen++;
            @(posedge clk);
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: %0d cycles with done high expected 0", done_seen);
        end
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: ready got %b expected 1", req_ready);
        end
        check_reg("midrst_reg5", 5'd5, 32'd0);
        run_req("post_rst", 5'd0, 5'd0, 5'd5, 32'd4, 1'b1, 1'b0, 32'd0, 32'd4, 32'd4);
        check_reg("post_rst_reg5", 5'd5, 32'd4);
    endtask

    initial begin
        test_reset();
        test_imm_and_dependent();
        test_wrap();
        test_write_x0();
        test_branch();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound so a stuck design still ends the run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle operand issuer and write-back controller that drives the shared ALU. It accepts one register-register or register-immediate add request at a time, reads operands from an internal register file, presents them to the ALU with the ALU enable held, captures the sum and equality flag, and writes the sum back. It sits between the instruction decode path and the ALU, and is the source of every `ALUctrl`/`ALUop1`/`ALUop2` and the consumer of every `ALUout`/`EQ`.

## Interface
- `DATA_WIDTH`, 32: operand, result and register width.
- `ADDR_WIDTH`, 5: register index width; the register file has `2**ADDR_WIDTH` entries.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: sequencer can accept a request.
- `rs1`, `rs2`, `rd`  in  ADDR_WIDTH each: source and destination register indices.
- `imm`  in  DATA_WIDTH: immediate operand.
- `use_imm`  in  1: 1 selects `imm` as op2 instead of `reg[rs2]`.
- `is_branch`  in  1: 1 selects a compare-only request with no write-back.
- `ALUctrl`  out  1: ALU enable.
- `ALUop1`, `ALUop2`  out  DATA_WIDTH: ALU operands.
- `ALUout`  in  DATA_WIDTH: ALU sum.
- `EQ`  in  1: ALU equality flag.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  DATA_WIDTH: last captured `ALUout`.
- `branch_taken`  out  1: last captured `EQ`, branch requests only.
- `a0`  out  DATA_WIDTH: continuous copy of `reg[10]`.
- `dbg_addr`  in  ADDR_WIDTH: debug read index.
- `dbg_data`  out  DATA_WIDTH: combinational `reg[dbg_addr]`.

## Operation
- FSM has three states: IDLE, EXEC, WB.
- **IDLE:** `req_ready`=1. When `req_valid & req_ready` at a rising edge:
  - Latch `op1`=`reg[rs1]` and `op2`=`use_imm ? imm : reg[rs2]`.
  - Latch `rd` and `is_branch`.
  - Go to EXEC.
- **EXEC:**
  - `ALUctrl`=1. `ALUop1`/`ALUop2` are driven from the latched operand registers, stable for the whole state.
  - At the closing edge, capture `ALUout`→`result`.
  - For branch requests, also capture `EQ`→`branch_taken`.
  - Go to WB.
- **WB:**
  - `done`=1.
  - If `!is_branch && rd!=0`, write `result` to `reg[rd]` at the closing edge.
  - Go to IDLE.
- **Outside EXEC:** `ALUctrl`=0 and `ALUop1`/`ALUop2` hold their last values. Operands never change while `ALUctrl`=1.
- **Register 0:** reads as 0. Writes to it are discarded, but `done`/`result` still update.
- **Arithmetic:** the sum is modulo 2^DATA_WIDTH; the carry is dropped. The sequencer performs no arithmetic of its own.
- **Branch requests:** `result` is still captured. `branch_taken` is left unchanged by non-branch requests.
- **Hazards:** operand reads happen in IDLE, after any prior WB has committed, so back-to-back dependent requests see the updated value. No forwarding is needed.
- **Request inputs:** ignored outside the accepting edge. `req_valid` with `req_ready`=0 is held off by the requester.

## Timing
- Handshake at edge k → EXEC during cycle k+1 → WB (`done`=1) during cycle k+2 → `req_ready`=1 again in cycle k+3.
- Latency is 2 cycles from acceptance to `done`. Throughput is one request per 3 cycles.
- `result`/`branch_taken` are valid from the cycle `done` rises and hold until the next EXEC completes.
- The register write is visible on `dbg_data`/`a0` in cycle k+3.
- **Reset (`rst`=0, asynchronous, any state):**
  - State returns to IDLE and every register-file entry is cleared.
  - `ALUctrl`=0, `ALUop1`=`ALUop2`=0, `done`=0, `result`=0, `branch_taken`=0, `a0`=0.
  - `req_ready`=0 while `rst` is low.
- **Reset mid-operation:** any in-flight request is abandoned. No write-back and no `done` pulse.
- **After release:** `req_ready`=1 in the first cycle with `rst` high.

## Test plan
- **Reset:** drive `rst`=0 mid-traffic → `ALUctrl`=0, `done`=0, `result`=0, `dbg_data`=0 for all addresses; `req_ready`=1 in the first cycle after release.
- **Immediate load and dependent add:**
  - `rs1`=0, `imm`=5, `use_imm`=1, `rd`=1 → in EXEC `ALUop1`=0, `ALUop2`=5, `ALUctrl`=1; `done` 2 cycles after acceptance; `result`=5; `reg[1]`=5.
  - Immediately follow with `rs1`=1, `rs2`=1, `rd`=10 → `result`=10, `a0`=10.
- **Wrap-around:** load `reg[3]`=0xFFFFFFFF, then `rs1`=3, `imm`=1, `use_imm`=1, `rd`=3 → `result`=0, `reg[3]`=0.
- **Write to x0:** `rs1`=0, `imm`=7, `use_imm`=1, `rd`=0 → `done` pulses, `result`=7, `dbg_data`@0 stays 0.
- **Branch, equal:** `reg[1]`=`reg[2]`=9, `is_branch`=1, `rd`=4 → `branch_taken`=1, `reg[4]` unchanged.
- **Branch, unequal, with subsequent add:**
  - `reg[2]`=8, same request → `branch_taken`=0 (ALU model clears `EQ` on mismatch).
  - A following non-branch add leaves `branch_taken`=0.
- **Reset mid-EXEC:** assert `rst` during EXEC of `rd`=5, `imm`=3 → `ALUctrl` drops the same cycle, no `done` pulse, `reg[5]`=0, FSM in IDLE.
